// File: rtl/apb_acc_driver.sv
// apb_acc_driver
// ---------------------------------------------------------------------------
// APB initiator that feeds samples to the FIR accelerator's APB slave.
// For each accepted sample it issues one APB write of the sample to
// REG_ACC_IN (BASE_ADDR+0x04). It then idles for SETTLE_CYCLES so the FIR
// pipeline can produce its output, and reads REG_ACC_OUT (BASE_ADDR+0x08).
// The read value is returned on a valid/ready result stream.
//
// Ports
//   HCLK, HRESET        clock (rising edge) and synchronous active-high reset
//   s_valid/s_ready     sample input handshake, s_data = sample
//   r_valid/r_ready     result output handshake, r_data = read value,
//                       r_err = slave error or timeout during this sample
//   busy                high whenever the FSM is not idle
//   sample_count        number of acknowledged writes since reset (wraps)
//   PADDR..PSLVERR      APB initiator signals
//
// Every output is a flop; the next-state and next-output values are
// computed together in one combinational block from state_d.
// ---------------------------------------------------------------------------
module apb_acc_driver #(
    parameter int                          APB_ADDR_WIDTH = 12,
    parameter logic [APB_ADDR_WIDTH-1:0]   BASE_ADDR      = '0,
    parameter int                          SETTLE_CYCLES  = 6,
    parameter int                          TIMEOUT        = 16
) (
    input  logic                        HCLK,
    input  logic                        HRESET,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [31:0]                 s_data,
    output logic                        r_valid,
    input  logic                        r_ready,
    output logic [31:0]                 r_data,
    output logic                        r_err,
    output logic                        busy,
    output logic [31:0]                 sample_count,
    output logic [APB_ADDR_WIDTH-1:0]   PADDR,
    output logic [31:0]                 PWDATA,
    output logic                        PWRITE,
    output logic                        PSEL,
    output logic                        PENABLE,
    input  logic [31:0]                 PRDATA,
    input  logic                        PREADY,
    input  logic                        PSLVERR
);

    localparam logic [APB_ADDR_WIDTH-1:0] ADDR_IN  = BASE_ADDR + APB_ADDR_WIDTH'(4);
    localparam logic [APB_ADDR_WIDTH-1:0] ADDR_OUT = BASE_ADDR + APB_ADDR_WIDTH'(8);

    // Counters count 0..N-1 and compare against the last value, so N fits.
    localparam int ST_W     = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int ST_LAST  = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;
    localparam int TO_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int TO_LAST  = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    typedef enum logic [2:0] {
        IDLE,
        WR_SETUP,
        WR_ACCESS,
        SETTLE,
        RD_SETUP,
        RD_ACCESS,
        RESP
    } state_t;

    state_t                       state_q, state_d;
    logic                         err_q, err_d;
    logic [ST_W-1:0]              settle_cnt_q, settle_cnt_d;
    logic [TO_W-1:0]              tmo_cnt_q, tmo_cnt_d;
    logic [31:0]                  count_q, count_d;
    logic [31:0]                  r_data_q, r_data_d;
    logic                         r_err_q, r_err_d;
    logic                         r_valid_q, r_valid_d;
    logic                         s_ready_q, s_ready_d;
    logic                         busy_q, busy_d;
    logic [APB_ADDR_WIDTH-1:0]    paddr_q, paddr_d;
    logic [31:0]                  pwdata_q, pwdata_d;
    logic                         pwrite_q, pwrite_d;
    logic                         psel_q, psel_d;
    logic                         penable_q, penable_d;

    always_comb begin
        state_d      = state_q;
        err_d        = err_q;
        settle_cnt_d = settle_cnt_q;
        tmo_cnt_d    = tmo_cnt_q;
        count_d      = count_q;
        r_data_d     = r_data_q;
        paddr_d      = paddr_q;
        pwdata_d     = pwdata_q;
        pwrite_d     = pwrite_q;

        unique case (state_q)
            IDLE: begin
                // s_ready_q gates acceptance so nothing is taken in the
                // cycle right after reset, when s_ready is still low.
                if (s_valid && s_ready_q) begin
                    err_d    = 1'b0;
                    pwdata_d = s_data;   // PWDATA doubles as the sample latch
                    state_d  = WR_SETUP;
                end
            end
            WR_SETUP: begin
                tmo_cnt_d = '0;
                state_d   = WR_ACCESS;
            end
            WR_ACCESS: begin
                if (PREADY) begin
                    err_d   = err_q | PSLVERR;
                    count_d = count_q + 32'd1;
                    if (SETTLE_CYCLES == 0) begin
                        state_d = RD_SETUP;
                    end else begin
                        settle_cnt_d = '0;
                        state_d      = SETTLE;
                    end
                end else if (TIMEOUT != 0) begin
                    // Abandon the sample entirely: no read, no count.
                    if (tmo_cnt_q == TO_W'(TO_LAST)) begin
                        err_d    = 1'b1;
                        r_data_d = 32'hFFFF_FFFF;
                        state_d  = RESP;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + 1'b1;
                    end
                end
            end
            SETTLE: begin
                if (settle_cnt_q == ST_W'(ST_LAST)) begin
                    state_d = RD_SETUP;
                end else begin
                    settle_cnt_d = settle_cnt_q + 1'b1;
                end
            end
            RD_SETUP: begin
                tmo_cnt_d = '0;
                state_d   = RD_ACCESS;
            end
            RD_ACCESS: begin
                if (PREADY) begin
                    r_data_d = PRDATA;
                    err_d    = err_q | PSLVERR;
                    state_d  = RESP;
                end else if (TIMEOUT != 0) begin
                    if (tmo_cnt_q == TO_W'(TO_LAST)) begin
                        err_d    = 1'b1;
                        r_data_d = 32'hFFFF_FFFF;
                        state_d  = RESP;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + 1'b1;
                    end
                end
            end
            RESP: begin
                if (r_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Address phase values are loaded when a SETUP state is entered and
        // then held through the matching ACCESS state.
        if (state_d == WR_SETUP) begin
            paddr_d  = ADDR_IN;
            pwrite_d = 1'b1;
        end
        if (state_d == RD_SETUP) begin
            paddr_d  = ADDR_OUT;
            pwrite_d = 1'b0;
            pwdata_d = 32'h0;
        end

        // Registered outputs follow the state being entered.
        s_ready_d = (state_d == IDLE);
        busy_d    = (state_d != IDLE);
        psel_d    = (state_d == WR_SETUP) || (state_d == WR_ACCESS) ||
                    (state_d == RD_SETUP) || (state_d == RD_ACCESS);
        penable_d = (state_d == WR_ACCESS) || (state_d == RD_ACCESS);
        r_valid_d = (state_d == RESP);
        r_err_d   = (state_d == RESP) ? err_d : 1'b0;
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q      <= IDLE;
            err_q        <= 1'b0;
            settle_cnt_q <= '0;
            tmo_cnt_q    <= '0;
            count_q      <= 32'h0;
            r_data_q     <= 32'h0;
            r_err_q      <= 1'b0;
            r_valid_q    <= 1'b0;
            s_ready_q    <= 1'b0;
            busy_q       <= 1'b0;
            paddr_q      <= '0;
            pwdata_q     <= 32'h0;
            pwrite_q     <= 1'b0;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            err_q        <= err_d;
            settle_cnt_q <= settle_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            count_q      <= count_d;
            r_data_q     <= r_data_d;
            r_err_q      <= r_err_d;
            r_valid_q    <= r_valid_d;
            s_ready_q    <= s_ready_d;
            busy_q       <= busy_d;
            paddr_q      <= paddr_d;
            pwdata_q     <= pwdata_d;
            pwrite_q     <= pwrite_d;
            psel_q       <= psel_d;
            penable_q    <= penable_d;
        end
    end

    assign s_ready      = s_ready_q;
    assign r_valid      = r_valid_q;
    assign r_data       = r_data_q;
    assign r_err        = r_err_q;
    assign busy         = busy_q;
    assign sample_count = count_q;
    assign PADDR        = paddr_q;
    assign PWDATA       = pwdata_q;
    assign PWRITE       = pwrite_q;
    assign PSEL         = psel_q;
    assign PENABLE      = penable_q;

endmodule

// File: tb/tb_apb_acc_driver.sv
// Directed testbench for apb_acc_driver (default parameters: base 0x000,
// settle 6 cycles, timeout 16). A small APB responder inside step() answers
// accesses with a configurable number of wait states, error and read data.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
module tb_apb_acc_driver;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        r_valid;
    logic        r_ready;
    logic [31:0] r_data;
    logic        r_err;
    logic        busy;
    logic [31:0] sample_count;
    logic [11:0] PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE;
    logic        PSEL;
    logic        PENABLE;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    apb_acc_driver dut (
        .HCLK         (HCLK),
        .HRESET       (HRESET),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .r_valid      (r_valid),
        .r_ready      (r_ready),
        .r_data       (r_data),
        .r_err        (r_err),
        .busy         (busy),
        .sample_count (sample_count),
        .PADDR        (PADDR),
        .PWDATA       (PWDATA),
        .PWRITE       (PWRITE),
        .PSEL         (PSEL),
        .PENABLE      (PENABLE),
        .PRDATA       (PRDATA),
        .PREADY       (PREADY),
        .PSLVERR      (PSLVERR)
    );

    always #5 HCLK = ~HCLK;

    int checks = 0;
    int errors = 0;

    // responder configuration
    int          wr_wait_cfg;
    int          rd_wait_cfg;
    bit          wr_stuck;
    bit          wr_err_cfg;
    bit          rd_err_cfg;
    logic [31:0] rdata_cfg;
    int          wait_cnt;

    // monitors
    int          n_wr_acc;
    int          n_rd_acc;
    int          n_rd_setup;
    int          n_addr_bad;
    int          n_stall_break;
    bit          prev_stall;
    logic [31:0] exp_wdata;

    task automatic clear_mon();
        wr_wait_cfg   = 0;
        rd_wait_cfg   = 0;
        wr_stuck      = 1'b0;
        wr_err_cfg    = 1'b0;
        rd_err_cfg    = 1'b0;
        rdata_cfg     = 32'h0;
        wait_cnt      = 0;
        n_wr_acc      = 0;
        n_rd_acc      = 0;
        n_rd_setup    = 0;
        n_addr_bad    = 0;
        n_stall_break = 0;
        prev_stall    = 1'b0;
    endtask

    // Advance to the next falling edge, record what the DUT shows there and
    // set up the responder inputs for the following rising edge.
    task automatic step();
        @(negedge HCLK);
        if (PSEL && PWRITE && (PADDR !== 12'h004 || PWDATA !== exp_wdata)) n_addr_bad++;
        if (PSEL && !PWRITE && (PADDR !== 12'h008 || PWDATA !== 32'h0)) n_addr_bad++;
        if (PSEL && PENABLE && PWRITE) n_wr_acc++;
        if (PSEL && PENABLE && !PWRITE) n_rd_acc++;
        if (PSEL && !PENABLE && !PWRITE) n_rd_setup++;
        if (prev_stall && !(PSEL && PENABLE)) n_stall_break++;
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        PRDATA  = 32'h0;
        if (PSEL && PENABLE) begin
            if (PWRITE) begin
                if (!wr_stuck && wait_cnt >= wr_wait_cfg) begin
                    PREADY  = 1'b1;
                    PSLVERR = wr_err_cfg;
                end else begin
                    wait_cnt++;
                end
            end else begin
                if (wait_cnt >= rd_wait_cfg) begin
                    PREADY  = 1'b1;
                    PSLVERR = rd_err_cfg;
                    PRDATA  = rdata_cfg;
                end else begin
                    wait_cnt++;
                end
            end
        end else begin
            wait_cnt = 0;
        end
        prev_stall = PSEL && PENABLE && !PREADY;
    endtask

    // Called at a falling edge with s_ready high; returns at cycle 1.
    task automatic accept_sample(input logic [31:0] d, input bit hold_valid);
        s_valid = 1'b1;
        s_data  = d;
        @(posedge HCLK);
        step();
        if (!hold_valid) s_valid = 1'b0;
    endtask

    // Steps until r_valid is seen; cyc is the cycle index counted from the
    // accept edge (cycle 1 = first cycle after it). Bounded at 100.
    task automatic run_to_resp(output int cyc);
        cyc = 1;
        while (r_valid !== 1'b1 && cyc < 100) begin
            step();
            cyc++;
        end
    endtask

    task automatic do_reset();
        HRESET  = 1'b1;
        s_valid = 1'b0;
        r_ready = 1'b1;
        step();
        HRESET = 1'b0;
        step();
    endtask

    task automatic test_reset();
        clear_mon();
        exp_wdata = 32'h0;
        HRESET  = 1'b1;
        s_valid = 1'b1;
        s_data  = 32'hDEAD_BEEF;
        r_ready = 1'b1;
        PREADY  = 1'b1;
        PSLVERR = 1'b1;
        PRDATA  = 32'h1234_5678;
        step();
        checks++;
        if ({s_ready, r_valid, r_err, busy, PWRITE, PSEL, PENABLE} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 0000000",
                     {s_ready, r_valid, r_err, busy, PWRITE, PSEL, PENABLE});
        end
        checks++;
        if (r_data !== 32'h0 || sample_count !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: got r_data=%h count=%h want 0/0", r_data, sample_count);
        end
        checks++;
        if (PADDR !== 12'h0 || PWDATA !== 32'h0) begin
            errors++;
            $display("FAIL reset_apb: got PADDR=%h PWDATA=%h want 0/0", PADDR, PWDATA);
        end
        HRESET  = 1'b0;
        s_valid = 1'b0;
        step();
        checks++;
        if (s_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got s_ready=%b busy=%b want 1/0", s_ready, busy);
        end
        $display("txn reset: s_ready=%b busy=%b", s_ready, busy);
    endtask

    task automatic test_basic();
        int cyc;
        clear_mon();
        exp_wdata = 32'h0000_0123;
        rdata_cfg = 32'h0000_ABCD;
        accept_sample(32'h0000_0123, 1'b0);
        checks++;
        if ({PSEL, PENABLE, PWRITE} !== 3'b101 || PADDR !== 12'h004 || PWDATA !== 32'h123) begin
            errors++;
            $display("FAIL basic_wr_setup: got sel/en/wr=%b PADDR=%h PWDATA=%h want 101/004/123",
                     {PSEL, PENABLE, PWRITE}, PADDR, PWDATA);
        end
        run_to_resp(cyc);
        checks++;
        if (cyc !== 11) begin
            errors++;
            $display("FAIL basic_latency: got %0d want 11", cyc);
        end
        checks++;
        if (r_data !== 32'h0000_ABCD || r_err !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: got %h err=%b want 0000abcd err=0", r_data, r_err);
        end
        checks++;
        if (sample_count !== 32'd1 || n_addr_bad !== 0 || n_rd_setup !== 1) begin
            errors++;
            $display("FAIL basic_apb: got count=%0d addr_bad=%0d rd_setup=%0d want 1/0/1",
                     sample_count, n_addr_bad, n_rd_setup);
        end
        step();
        checks++;
        if (r_valid !== 1'b0 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_return: got r_valid=%b s_ready=%b want 0/1", r_valid, s_ready);
        end
        $display("txn basic: cyc=%0d r_data=%h r_err=%b count=%0d", cyc, r_data, r_err, sample_count);
    endtask

    task automatic test_wait_states();
        int cyc;
        clear_mon();
        wr_wait_cfg = 3;
        rd_wait_cfg = 2;
        exp_wdata   = 32'h0000_0456;
        rdata_cfg   = 32'h0000_7777;
        accept_sample(32'h0000_0456, 1'b0);
        run_to_resp(cyc);
        checks++;
        if (cyc !== 16) begin
            errors++;
            $display("FAIL wait_latency: got %0d want 16", cyc);
        end
        checks++;
        if (n_stall_break !== 0 || n_addr_bad !== 0) begin
            errors++;
            $display("FAIL wait_stable: got psel_drops=%0d addr_bad=%0d want 0/0",
                     n_stall_break, n_addr_bad);
        end
        checks++;
        if (n_wr_acc !== 4 || n_rd_acc !== 3) begin
            errors++;
            $display("FAIL wait_access_cycles: got wr=%0d rd=%0d want 4/3", n_wr_acc, n_rd_acc);
        end
        checks++;
        if (r_data !== 32'h0000_7777 || r_err !== 1'b0 || sample_count !== 32'd2) begin
            errors++;
            $display("FAIL wait_result: got %h err=%b count=%0d want 00007777/0/2",
                     r_data, r_err, sample_count);
        end
        step();
        $display("txn wait_states: cyc=%0d r_data=%h count=%0d", cyc, r_data, sample_count);
    endtask

    task automatic test_timeout();
        int cyc;
        do_reset();
        clear_mon();
        wr_stuck  = 1'b1;
        exp_wdata = 32'h0000_0999;
        rdata_cfg = 32'h1111_1111;
        accept_sample(32'h0000_0999, 1'b0);
        run_to_resp(cyc);
        checks++;
        if (cyc !== 18 || n_wr_acc !== 16) begin
            errors++;
            $display("FAIL timeout_cycles: got resp_cyc=%0d wr_acc=%0d want 18/16", cyc, n_wr_acc);
        end
        checks++;
        if (n_rd_setup !== 0 || n_rd_acc !== 0 || PSEL !== 1'b0) begin
            errors++;
            $display("FAIL timeout_no_read: got rd_setup=%0d rd_acc=%0d PSEL=%b want 0/0/0",
                     n_rd_setup, n_rd_acc, PSEL);
        end
        checks++;
        if (r_data !== 32'hFFFF_FFFF || r_err !== 1'b1 || sample_count !== 32'd0) begin
            errors++;
            $display("FAIL timeout_result: got %h err=%b count=%0d want ffffffff/1/0",
                     r_data, r_err, sample_count);
        end
        step();
        $display("txn timeout: cyc=%0d r_data=%h r_err=%b count=%0d", cyc, r_data, r_err, sample_count);
    endtask

    task automatic test_slverr();
        int cyc;
        clear_mon();
        wr_err_cfg = 1'b1;
        exp_wdata  = 32'h0000_0ABC;
        rdata_cfg  = 32'h5A5A_0001;
        accept_sample(32'h0000_0ABC, 1'b0);
        run_to_resp(cyc);
        checks++;
        if (cyc !== 11 || n_rd_setup !== 1 || n_rd_acc !== 1) begin
            errors++;
            $display("FAIL slverr_read_issued: got cyc=%0d rd_setup=%0d rd_acc=%0d want 11/1/1",
                     cyc, n_rd_setup, n_rd_acc);
        end
        checks++;
        if (r_data !== 32'h5A5A_0001 || r_err !== 1'b1 || sample_count !== 32'd1) begin
            errors++;
            $display("FAIL slverr_result: got %h err=%b count=%0d want 5a5a0001/1/1",
                     r_data, r_err, sample_count);
        end
        step();
        $display("txn slverr: r_data=%h r_err=%b count=%0d", r_data, r_err, sample_count);
    endtask

    task automatic test_back_to_back();
        int cyc;
        int bad;
        clear_mon();
        r_ready   = 1'b0;
        exp_wdata = 32'h0000_0111;
        rdata_cfg = 32'h0000_2222;
        accept_sample(32'h0000_0111, 1'b1);
        s_data = 32'h0000_0333;
        run_to_resp(cyc);
        checks++;
        if (cyc !== 11 || r_data !== 32'h0000_2222 || r_err !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first: got cyc=%0d %h err=%b want 11/00002222/0", cyc, r_data, r_err);
        end
        // r_ready stays low for this RESP cycle plus four more
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (r_valid !== 1'b1 || r_data !== 32'h0000_2222 || r_err !== 1'b0 ||
                s_ready !== 1'b0 || PSEL !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL b2b_hold: got %0d bad hold cycles want 0", bad);
        end
        r_ready   = 1'b1;
        exp_wdata = 32'h0000_0333;
        rdata_cfg = 32'h0000_4444;
        step();
        checks++;
        if (r_valid !== 1'b0 || s_ready !== 1'b1 || PSEL !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: got r_valid=%b s_ready=%b PSEL=%b want 0/1/0",
                     r_valid, s_ready, PSEL);
        end
        step();
        s_valid = 1'b0;
        checks++;
        if ({PSEL, PENABLE, PWRITE} !== 3'b101 || PWDATA !== 32'h0000_0333) begin
            errors++;
            $display("FAIL b2b_second_write: got sel/en/wr=%b PWDATA=%h want 101/00000333",
                     {PSEL, PENABLE, PWRITE}, PWDATA);
        end
        run_to_resp(cyc);
        checks++;
        if (cyc !== 11 || r_data !== 32'h0000_4444 || sample_count !== 32'd3 || n_addr_bad !== 0) begin
            errors++;
            $display("FAIL b2b_second: got cyc=%0d %h count=%0d addr_bad=%0d want 11/00004444/3/0",
                     cyc, r_data, sample_count, n_addr_bad);
        end
        step();
        $display("txn back_to_back: r_data=%h count=%0d", r_data, sample_count);
    endtask

    task automatic test_reset_mid();
        int k;
        int seen;
        clear_mon();
        rd_wait_cfg = 4;
        exp_wdata   = 32'h0000_0AAA;
        rdata_cfg   = 32'h0000_BBBB;
        accept_sample(32'h0000_0AAA, 1'b0);
        k = 0;
        while (!(PSEL === 1'b1 && PENABLE === 1'b1 && PWRITE === 1'b0) && k < 40) begin
            step();
            k++;
        end
        checks++;
        if (n_rd_acc !== 1) begin
            errors++;
            $display("FAIL rstmid_reach_read: got rd_acc=%0d want 1", n_rd_acc);
        end
        HRESET = 1'b1;
        step();
        checks++;
        if ({PSEL, PENABLE, r_valid, busy, s_ready} !== 5'b0 || sample_count !== 32'd0) begin
            errors++;
            $display("FAIL rstmid_clear: got sel/en/rv/busy/sr=%b count=%0d want 00000/0",
                     {PSEL, PENABLE, r_valid, busy, s_ready}, sample_count);
        end
        HRESET = 1'b0;
        step();
        checks++;
        if (s_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_release: got s_ready=%b busy=%b want 1/0", s_ready, busy);
        end
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (r_valid !== 1'b0 || PSEL !== 1'b0) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL rstmid_no_response: got %0d active cycles want 0", seen);
        end
        $display("txn reset_mid: s_ready=%b count=%0d", s_ready, sample_count);
    endtask

    initial begin
        HRESET  = 1'b1;
        s_valid = 1'b0;
        s_data  = 32'h0;
        r_ready = 1'b1;
        PRDATA  = 32'h0;
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        test_reset();
        test_basic();
        test_wait_states();
        test_timeout();
        test_slverr();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
